// File: rtl/fifo_async_pkg.sv
// Shared constants and Gray-code helpers for both domains of the asynchronous FIFO.
package fifo_async_pkg;

  localparam int unsigned PTR_WIDTH_DEF   = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEPTH           = 2 ** (PTR_WIDTH_DEF - 1);

  // Helpers operate on a wide container; callers zero-extend and truncate to their width.
  localparam int unsigned GRAY_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = gray;
    bin = bin ^ (bin >> 1);
    bin = bin ^ (bin >> 2);
    bin = bin ^ (bin >> 4);
    bin = bin ^ (bin >> 8);
    bin = bin ^ (bin >> 16);
    return bin;
  endfunction

endpackage

// File: rtl/fifo_async_sync.sv
// N-stage flop synchronizer for a Gray-coded pointer crossing into clk_in.
module fifo_async_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_in,
  input  logic             nrst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the asynchronous value through the flop chain.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_read_ptr.sv
// Read-domain pointer and flag logic for the asynchronous FIFO.
// Optional sticky underflow flag: define FIFO_ASYNC_RD_UNDERFLOW_EN.
module fifo_async_read_ptr
  import fifo_async_pkg::*;
#(
  parameter int unsigned PTR_WIDTH       = PTR_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 read_in,
  input  logic [PTR_WIDTH-1:0] wptr_g_async_in,
  output logic [PTR_WIDTH-2:0] raddr_out,
  output logic [PTR_WIDTH-1:0] rptr_b_out,
  output logic [PTR_WIDTH-1:0] rptr_g_out,
  output logic                 empty_out,
  output logic                 almost_empty_out,
  output logic [PTR_WIDTH-1:0] rd_level_out
`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
  ,
  output logic                 underflow_out
`endif
);

  logic [PTR_WIDTH-1:0] wptr_g_sync;
  logic [PTR_WIDTH-1:0] wptr_b_sync;
  logic                 accept;
  logic [PTR_WIDTH-1:0] rptr_b_next;
  logic [PTR_WIDTH-1:0] rptr_g_next;
  logic [PTR_WIDTH-1:0] level_next;

  fifo_async_sync #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .d_in    (wptr_g_async_in),
    .q_out   (wptr_g_sync)
  );

  // Next pointers and flags, computed from the post-accept pointer so flags need no extra cycle.
  always_comb begin
    wptr_b_sync = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(wptr_g_sync)));
    accept      = read_in & ~empty_out;
    rptr_b_next = rptr_b_out + PTR_WIDTH'(accept);
    rptr_g_next = PTR_WIDTH'(bin2gray(GRAY_MAX_W'(rptr_b_next)));
    level_next  = wptr_b_sync - rptr_b_next;
  end

  // Pointer, flag and level registers.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rptr_b_out       <= '0;
      rptr_g_out       <= '0;
      empty_out        <= 1'b1;
      almost_empty_out <= 1'b1;
      rd_level_out     <= '0;
    end else begin
      rptr_b_out       <= rptr_b_next;
      rptr_g_out       <= rptr_g_next;
      empty_out        <= (rptr_g_next == wptr_g_sync);
      almost_empty_out <= (32'(level_next) <= ALMOST_EMPTY_TH);
      rd_level_out     <= level_next;
    end
  end

  assign raddr_out = rptr_b_out[PTR_WIDTH-2:0];

`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
  // Sticky flag for reads attempted while empty; only reset clears it.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      underflow_out <= 1'b0;
    end else if (read_in && empty_out) begin
      underflow_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_async_read_ptr.sv
// Self-checking bench for fifo_async_read_ptr against an occupancy-count reference model.
module tb_fifo_async_read_ptr;

  localparam int unsigned PW  = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned AE  = 1;
  localparam int unsigned MOD = 1 << PW;

  logic          clk_in = 1'b0;
  logic          nrst_in;
  logic          read_in;
  logic [PW-1:0] wptr_g_async_in;
  logic [PW-2:0] raddr_out;
  logic [PW-1:0] rptr_b_out;
  logic [PW-1:0] rptr_g_out;
  logic          empty_out;
  logic          almost_empty_out;
  logic [PW-1:0] rd_level_out;
`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
  logic          underflow_out;
`endif

  fifo_async_read_ptr #(
    .PTR_WIDTH       (PW),
    .SYNC_STAGES     (SS),
    .ALMOST_EMPTY_TH (AE)
  ) dut (
    .clk_in           (clk_in),
    .nrst_in          (nrst_in),
    .read_in          (read_in),
    .wptr_g_async_in  (wptr_g_async_in),
    .raddr_out        (raddr_out),
    .rptr_b_out       (rptr_b_out),
    .rptr_g_out       (rptr_g_out),
    .empty_out        (empty_out),
    .almost_empty_out (almost_empty_out),
    .rd_level_out     (rd_level_out)
`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
    ,
    .underflow_out    (underflow_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: total entries written / read, and the write counts seen by the read side.
  int unsigned wr_tot;
  int unsigned rd_tot;
  int unsigned hist[$];
  bit          m_empty;
  bit          m_ae;
  bit          m_uf;
  int unsigned m_level;

  function automatic int unsigned gray_of(input int unsigned b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_w();
    wptr_g_async_in = PW'(gray_of(wr_tot % MOD));
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < int'(SS); i++) hist.push_back(0);
    rd_tot  = 0;
    m_empty = 1'b1;
    m_ae    = 1'b1;
    m_level = 0;
    m_uf    = 1'b0;
  endtask

  // One clock edge in the model: the read side sees the write count from SS edges ago.
  task automatic model_edge();
    int unsigned seen;
    if (read_in && m_empty) m_uf = 1'b1;
    if (read_in && !m_empty) rd_tot++;
    seen = hist.pop_front();
    hist.push_back(wr_tot % MOD);
    m_level = (seen + MOD - (rd_tot % MOD)) % MOD;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rptr_b"}, 32'(rptr_b_out), rd_tot % MOD);
    chk({tag, ".rptr_g"}, 32'(rptr_g_out), gray_of(rd_tot % MOD));
    chk({tag, ".raddr"}, 32'(raddr_out), rd_tot % (MOD / 2));
    chk({tag, ".empty"}, 32'(empty_out), 32'(m_empty));
    chk({tag, ".aempty"}, 32'(almost_empty_out), 32'(m_ae));
    chk({tag, ".level"}, 32'(rd_level_out), m_level);
`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
    chk({tag, ".uflow"}, 32'(underflow_out), 32'(m_uf));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic apply_reset(input string tag);
    #2;
    nrst_in = 1'b0;
    read_in = 1'b0;
    wr_tot  = 0;
    drive_w();
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk_in);
    nrst_in = 1'b1;
  endtask

  int unsigned exp_b[3] = '{15, 0, 1};
  int unsigned exp_g[3] = '{8, 0, 1};
  int unsigned prev_g;

  initial begin
    nrst_in = 1'b0;
    read_in = 1'b0;
    wr_tot  = 0;
    drive_w();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_in);
    nrst_in = 1'b1;

    // Synchronizer latency: write pointer 0 -> 1 before edge 1, visible after edge 3.
    wr_tot = 1;
    drive_w();
    step("lat1");
    chk("lat1_empty_held", 32'(empty_out), 1);
    step("lat2");
    chk("lat2_empty_held", 32'(empty_out), 1);
    step("lat3");
    chk("lat3_empty_fall", 32'(empty_out), 0);
    chk("lat3_level", 32'(rd_level_out), 1);

    // Drain a full FIFO, plus one ignored read.
    apply_reset("rst_drain");
    wr_tot = 8;
    drive_w();
    repeat (3) step("fill8");
    chk("full_level", 32'(rd_level_out), 8);
    chk("full_empty", 32'(empty_out), 0);
    read_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("drain");
      chk("drain_level", 32'(rd_level_out), (i < 8) ? 32'(7 - i) : 32'd0);
    end
    read_in = 1'b0;
    chk("drain_rptr_b", 32'(rptr_b_out), 32'b1000);
    chk("drain_rptr_g", 32'(rptr_g_out), 32'b1100);
    chk("drain_raddr", 32'(raddr_out), 0);
    chk("drain_empty", 32'(empty_out), 1);

    // Wrap: advance the read pointer to 14, then read 3 entries across the wrap.
    wr_tot = 14;
    drive_w();
    repeat (3) step("pre_wrap_fill");
    read_in = 1'b1;
    repeat (6) step("pre_wrap_read");
    read_in = 1'b0;
    chk("pre_wrap_rptr_b", 32'(rptr_b_out), 14);
    wr_tot = 17;
    drive_w();
    repeat (3) step("wrap_fill");
    read_in = 1'b1;
    prev_g  = gray_of(14);
    for (int i = 0; i < 3; i++) begin
      step("wrap");
      chk("wrap_rptr_b", 32'(rptr_b_out), exp_b[i]);
      chk("wrap_rptr_g", 32'(rptr_g_out), exp_g[i]);
      chk("wrap_gray_1bit", 32'($countones(rptr_g_out ^ PW'(prev_g))), 1);
      prev_g = exp_g[i];
    end
    read_in = 1'b0;
    chk("wrap_empty", 32'(empty_out), 1);

    // Simultaneous read and synced write advance: level holds at 4.
    wr_tot = 21;
    drive_w();
    repeat (3) step("sim_fill");
    chk("sim_level_pre", 32'(rd_level_out), 4);
    wr_tot = 22;
    drive_w();
    step("sim_a");
    step("sim_b");
    read_in = 1'b1;
    step("sim_c");
    chk("sim_level", 32'(rd_level_out), 4);
    chk("sim_aempty", 32'(almost_empty_out), 0);
    read_in = 1'b0;

    // Randomized traffic, writer never more than a full FIFO ahead.
    for (int i = 0; i < 300; i++) begin
      read_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && (wr_tot - rd_tot) < (MOD / 2)) wr_tot++;
      drive_w();
      step("rand");
    end
    read_in = 1'b0;

    // Reset mid-operation with pointers at 5.
    apply_reset("rst_pre5");
    wr_tot = 7;
    drive_w();
    repeat (3) step("p5_fill");
    read_in = 1'b1;
    repeat (5) step("p5_read");
    read_in = 1'b0;
    chk("p5_rptr_b", 32'(rptr_b_out), 5);
    apply_reset("rst_mid");
    chk("rst_mid_rptr_b", 32'(rptr_b_out), 0);
    chk("rst_mid_empty", 32'(empty_out), 1);
    chk("rst_mid_level", 32'(rd_level_out), 0);

`ifdef FIFO_ASYNC_RD_UNDERFLOW_EN
    // Underflow is sticky through later traffic and cleared only by reset.
    read_in = 1'b1;
    step("uf_set");
    chk("uf_set_flag", 32'(underflow_out), 1);
    chk("uf_set_rptr", 32'(rptr_b_out), 0);
    read_in = 1'b0;
    wr_tot  = 2;
    drive_w();
    repeat (3) step("uf_fill");
    read_in = 1'b1;
    repeat (2) step("uf_traffic");
    read_in = 1'b0;
    chk("uf_held", 32'(underflow_out), 1);
    apply_reset("uf_rst");
    chk("uf_cleared", 32'(underflow_out), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_async_read_ptr.md
Name: fifo_async_read_ptr

Overview:
Read-domain pointer and flag logic for the asynchronous circular FIFO. It brings the write-side Gray pointer into the read clock domain through a multi-flop synchronizer and advances the binary and Gray read pointers on accepted reads. It also produces registered empty, almost-empty and fill-level outputs. It drives the read address of the dual-port RAM and returns its Gray pointer to the write side.

Parameters:
PTR_WIDTH, 4, pointer width including the wrap bit; FIFO depth = 2^(PTR_WIDTH-1).
SYNC_STAGES, 2, number of synchronizer flops on the incoming write Gray pointer; minimum 2.
ALMOST_EMPTY_TH, 1, almost_empty_out asserts when the fill level is at or below this value.

Ports:
clk_in  input  1  read-domain clock.
nrst_in  input  1  asynchronous active-low reset.
read_in  input  1  read request; accepted only when empty_out=0.
wptr_g_async_in  input  PTR_WIDTH  write Gray pointer from the write clock domain, unsynchronized.
raddr_out  output  PTR_WIDTH-1  RAM read address; equals rptr_b_out[PTR_WIDTH-2:0].
rptr_b_out  output  PTR_WIDTH  registered binary read pointer.
rptr_g_out  output  PTR_WIDTH  registered Gray read pointer, sent to the write-side synchronizer.
empty_out  output  1  registered empty flag.
almost_empty_out  output  1  registered almost-empty flag.
rd_level_out  output  PTR_WIDTH  registered fill level, range 0..2^(PTR_WIDTH-1).
underflow_out  output  1  sticky underflow error; present only with FIFO_ASYNC_RD_UNDERFLOW_EN.

Behaviour:
- Reset, applied asynchronously on nrst_in low:
  - rptr_b_out=0, rptr_g_out=0, every sync flop=0.
  - empty_out=1, almost_empty_out=1, rd_level_out=0, underflow_out=0.
- Synchronizer: SYNC_STAGES flops clocked on clk_in. Only the last stage is used (wptr_g_sync).
- wptr_b_sync = Gray-to-binary of wptr_g_sync (combinational).
- Accept and pointer update:
  - accept = read_in & ~empty_out.
  - rptr_b_next = rptr_b_out + accept, modulo 2^PTR_WIDTH.
  - rptr_g_next = (rptr_b_next >> 1) ^ rptr_b_next.
  - Both pointers register the next values every cycle.
- Empty: empty_out <= (rptr_g_next == wptr_g_sync). The flag is computed from the next pointer, so it is valid in the same cycle the pointer updates. No extra bubble.
- Level: rd_level_out <= wptr_b_sync - rptr_b_next, modulo 2^PTR_WIDTH.
- Almost-empty: almost_empty_out <= (level_next <= ALMOST_EMPTY_TH).
- Read data timing: the RAM is read at raddr_out. Data for an accepted read corresponds to the address presented in the accept cycle; the RAM read timing is owned by the RAM.
- Write-to-visible latency: a change on wptr_g_async_in stable before edge k reaches empty_out/rd_level_out after edge k+SYNC_STAGES.
- Read while empty: ignored; pointers hold and empty_out stays 1.
- Wrap-around:
  - Binary pointer rolls from 2^PTR_WIDTH-1 to 0; the Gray pointer follows with a single-bit change.
  - Full depth is distinguished from empty by the wrap bit (MSB).
- Simultaneous read and write-pointer advance in one cycle: both apply, and the level is unchanged net.
- Flag pessimism: empty and level are pessimistic (never falsely non-empty), because the synchronized write pointer lags the true one.
- Reset mid-operation: immediate return to reset values. The write side is reset by the same system reset.

Optional Feature:
FIFO_ASYNC_RD_UNDERFLOW_EN:
- Defined: the underflow_out port exists. It sets to 1 on the edge after any cycle with read_in=1 & empty_out=1, and holds until nrst_in.
- Undefined: the port and its logic are absent; reads while empty are silently ignored.

Decomposition:
- Shared package fifo_async_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width;
  - PTR_WIDTH and SYNC_STAGES defaults;
  - a DEPTH = 2^(PTR_WIDTH-1) constant.
- The write side uses the same package.
- One sub-module: fifo_async_sync, an N-stage flop synchronizer with parameterised width and stages and async active-low reset. It is reused for the write side's read-pointer sync.

Test Plan:
- Reset: nrst_in=0 mid-run with pointers at 5 -> immediately rptr_b_out=0, rptr_g_out=0, empty_out=1, almost_empty_out=1, rd_level_out=0.
- Sync latency (PTR_WIDTH=4, SYNC_STAGES=2): wptr_g_async_in 0000->0001 before edge 1 -> empty_out falls and rd_level_out=1 after edge 3, not earlier.
- Drain full FIFO: wptr_g_async_in=1100 (bin 8), read_in held high 9 cycles:
  - rd_level_out goes 8,7,...,0;
  - empty_out rises on the 8th accept edge; rptr_b_out=1000, rptr_g_out=1100, raddr_out=000;
  - the 9th read is ignored.
- Wrap: start rptr_b_out=1110, wptr bin 0001 (3 entries), read 3 -> rptr_b_out sequence 1111, 0000, 0001. Gray sequence 1000, 0000, 0001, each step a single-bit change. empty_out=1 at the end.
- Simultaneous: level 4, read_in=1 while the synced write pointer advances by 1 -> rd_level_out stays 4, and almost_empty_out=0 with ALMOST_EMPTY_TH=1.
- Underflow (macro defined): read_in=1 while empty -> underflow_out=1 next edge and stays 1 after traffic resumes. Pointers unchanged. Cleared only by nrst_in.
